// File: rtl/adld_operand_seq.sv
// adld_operand_seq: upstream operand sequencer for the adld_hw late-arrival datapath.
//
// Buffers (a, b) operand pairs in a small FIFO, drives b to the datapath first and
// a_late LATE_DLY cycles later, then samples the datapath result SETTLE cycles after
// a_late moved and returns it on a valid/ready result interface.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_ready_o    operand pair handshake; in_a_i is the late operand,
//                              in_b_i the early one
//   b_o, a_late_o              registered operands driven to the datapath
//   out_fb_i                   combinational datapath result
//   res_valid_o / res_ready_i  result handshake, res_data_o holds the captured result
//   busy_o                     an op is in flight or entries are queued
module adld_operand_seq #(
    parameter int WIDTH    = 3,
    parameter int DEPTH    = 4,
    parameter int LATE_DLY = 1,
    parameter int SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] a_late_o,
    input  logic [WIDTH-1:0] out_fb_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             busy_o
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int MAXD = (LATE_DLY > SETTLE) ? LATE_DLY : SETTLE;
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SKEW, ST_SETTLE} state_t;

    state_t             state_q;
    logic [TW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_pend_q, b_q, a_late_q, res_data_q;
    logic               res_valid_q;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] head;
    logic               push, pop;

    assign in_ready_o = count_q != CW'(DEPTH);
    assign push       = in_valid_i && in_ready_o;
    // A stalled result blocks the next op so the held result is never overwritten.
    assign pop        = (state_q == ST_IDLE) && (count_q != '0) && (!res_valid_q || res_ready_i);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + CW'(1) :
                   (pop && !push) ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {in_a_i, in_b_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_pend_q    <= '0;
            b_q         <= '0;
            a_late_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            // Consumption clears valid; a capture later in this block overrides it.
            if (res_valid_q && res_ready_i)
                res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        b_q      <= head[WIDTH-1:0];
                        a_pend_q <= head[2*WIDTH-1:WIDTH];
                        cnt_q    <= TW'(LATE_DLY - 1);
                        state_q  <= ST_SKEW;
                    end
                end
                ST_SKEW: begin
                    if (cnt_q == '0) begin
                        a_late_q <= a_pend_q;
                        cnt_q    <= TW'(SETTLE - 1);
                        state_q  <= ST_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        res_data_q  <= out_fb_i;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign b_o         = b_q;
    assign a_late_o    = a_late_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != ST_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_adld_operand_seq.sv
// tb_adld_operand_seq: scoreboard bench for adld_operand_seq with out_fb = a_late ^ b.
module tb_adld_operand_seq;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, res_valid, res_ready, busy;
    logic [W-1:0] in_a, in_b, b, a_late, out_fb, res_data;
    logic         in_valid2, in_ready2, res_valid2, res_ready2, busy2;
    logic [W-1:0] in_a2, in_b2, b2, a_late2, out_fb2, res_data2;

    assign out_fb  = a_late ^ b;
    assign out_fb2 = a_late2 ^ b2;

    adld_operand_seq #(.WIDTH(W), .DEPTH(4), .LATE_DLY(1), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
        .b_o(b), .a_late_o(a_late), .out_fb_i(out_fb),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .busy_o(busy)
    );

    adld_operand_seq #(.WIDTH(W), .DEPTH(4), .LATE_DLY(3), .SETTLE(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_a_i(in_a2), .in_b_i(in_b2),
        .b_o(b2), .a_late_o(a_late2), .out_fb_i(out_fb2),
        .res_valid_o(res_valid2), .res_ready_i(res_ready2), .res_data_o(res_data2),
        .busy_o(busy2)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] held;
    logic         prev_stall = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] bb);
        bit taken = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = bb;
        for (int i = 0; i < 40 && !taken; i++) begin
            if (in_ready) begin
                taken = 1;
                exp_q.push_back(a ^ bb);
            end
            tick();
        end
        if (!taken) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got in_ready=0 for 40 cycles, want acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: consumes results on handshake and checks stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(res_valid), 1);
                chk("stall_data", int'(res_data), int'(held));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %0d, want none", res_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("result", int'(res_data), int'(exp_v));
                end
            end
            prev_stall = res_valid && !res_ready;
            held = res_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    logic [W-1:0] pa [6] = '{3'd6, 3'd7, 3'd5, 3'd7, 3'd7, 3'd2};
    logic [W-1:0] pb [6] = '{3'd7, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    logic [W-1:0] ra [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [W-1:0] rb [5] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2};

    initial begin
        int idx;
        int ncap;
        int tcap [2];
        int dcap [2];
        in_valid = 0; in_a = 0; in_b = 0; res_ready = 1;
        in_valid2 = 0; in_a2 = 0; in_b2 = 0; res_ready2 = 1;
        tick();
        tick();
        chk("rst_b", int'(b), 0);
        chk("rst_a_late", int'(a_late), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid2", int'(res_valid2), 0);
        rst_n = 1'b1;
        tick();

        // Single op timing with default parameters.
        push(3'd2, 3'd3);
        chk("t1_b_e0", int'(b), 0);
        tick();
        chk("t1_b_e1", int'(b), 3);
        chk("t1_a_late_e1", int'(a_late), 0);
        chk("t1_out_fb_e1", int'(out_fb), 3);
        tick();
        chk("t1_a_late_e2", int'(a_late), 2);
        chk("t1_valid_e2", int'(res_valid), 0);
        tick();
        chk("t1_valid_e3", int'(res_valid), 1);
        chk("t1_data_e3", int'(res_data), 1);
        tick();
        chk("t1_valid_e4", int'(res_valid), 0);
        chk("t1_busy_e4", int'(busy), 0);

        // Fill and backpressure: only 1 in flight + DEPTH queued are accepted.
        res_ready = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 6) begin
                in_valid = 1; in_a = pa[idx]; in_b = pb[idx];
                if (in_ready) begin
                    exp_q.push_back(pa[idx] ^ pb[idx]);
                    idx++;
                end
            end
            tick();
        end
        chk("fill_accepted", idx, 5);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_res_valid", int'(res_valid), 1);
        chk("fill_res_data", int'(res_data), 1);
        chk("fill_busy", int'(busy), 1);
        res_ready = 1;
        tick();
        // The edge above popped while full; the held push must not have been taken.
        chk("full_pop_no_push", int'(in_ready), 1);
        for (int c = 0; c < 20 && idx < 6; c++) begin
            if (in_ready) begin
                exp_q.push_back(pa[idx] ^ pb[idx]);
                idx++;
            end
            tick();
        end
        in_valid = 0;
        chk("fill_all_accepted", idx, 6);
        drain();

        // Wrap-around: 10 ops through a 4-entry FIFO.
        for (int i = 0; i < 10; i++) push(W'(i), W'(i * 3 + 1));
        drain();

        // Reset mid-SKEW with 3 entries queued.
        res_ready = 0;
        for (int i = 0; i < 5; i++) push(ra[i], rb[i]);
        res_ready = 1;
        tick();
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_b", int'(b), 5);
        rst_n = 1'b0;
        #1;
        chk("arst_b", int'(b), 0);
        chk("arst_a_late", int'(a_late), 0);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_res_data", int'(res_data), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_busy", int'(busy), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_result_after_rst", int'(res_valid), 0);
        end

        // LATE_DLY=3, SETTLE=2 instance.
        in_valid2 = 1; in_a2 = 3'd7; in_b2 = 3'd5;
        tick();
        in_valid2 = 0;
        chk("d_b_e0", int'(b2), 0);
        tick();
        chk("d_b_e1", int'(b2), 5);
        chk("d_a_late_e1", int'(a_late2), 0);
        tick();
        tick();
        chk("d_a_late_e3", int'(a_late2), 0);
        tick();
        chk("d_a_late_e4", int'(a_late2), 7);
        chk("d_valid_e4", int'(res_valid2), 0);
        tick();
        chk("d_valid_e5", int'(res_valid2), 0);
        tick();
        chk("d_valid_e6", int'(res_valid2), 1);
        chk("d_data_e6", int'(res_data2), 2);
        tick();

        // Back-to-back spacing on the delayed instance.
        in_valid2 = 1; in_a2 = 3'd1; in_b2 = 3'd2;
        tick();
        in_a2 = 3'd6; in_b2 = 3'd3;
        tick();
        in_valid2 = 0;
        ncap = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid2 && ncap < 2) begin
                tcap[ncap] = c;
                dcap[ncap] = int'(res_data2);
                ncap++;
            end
            tick();
        end
        chk("d_captures", ncap, 2);
        if (ncap == 2) begin
            chk("d_spacing", tcap[1] - tcap[0], 6);
            chk("d_res0", dcap[0], 3);
            chk("d_res1", dcap[1], 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adld_operand_seq.md
Name: adld_operand_seq

Overview:
- Upstream operand sequencer for the adld_hw late-arrival datapath.
- Accepts (a, b) operand pairs on a valid/ready input interface and buffers them in a small FIFO.
- Drives b first and a_late a programmable number of cycles later, reproducing the late-arrival timing the datapath is built for.
- Samples the datapath's combinational out after a settle window and returns it on a valid/ready result interface.

Parameters:
- WIDTH, 3, operand and result width in bits.
- DEPTH, 4, input FIFO entries; power of 2, ≥2.
- LATE_DLY, 1, cycles from b update to a_late update; ≥1.
- SETTLE, 1, cycles from a_late update to out sampling; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals (count != DEPTH), combinational from registered count.
- in_a  in  WIDTH  late operand.
- in_b  in  WIDTH  early operand.
- b  out  WIDTH  early operand to the datapath; registered.
- a_late  out  WIDTH  late operand to the datapath; registered.
- out_fb  in  WIDTH  datapath result (adld_hw out).
- res_valid  out  1  captured result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  WIDTH  captured result.
- busy  out  1  (state != IDLE) || (count != 0).

Behaviour:
- Reset: asynchronous on rst_n low, applied immediately.
  - FIFO emptied (count=0, pointers 0), state=IDLE, internal counter=0, a_pend=0.
  - Outputs b=0, a_late=0, res_valid=0, res_data=0.
  - in_ready=1 and busy=0 after reset.
  - Reset mid-operation discards the in-flight op and all queued entries; no result is produced for them.
- FIFO push: on in_valid && in_ready, {in_a, in_b} is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- FIFO pop: pop condition is state==IDLE && count!=0 && (!res_valid || res_ready).
  - On a pop, rd_ptr increments and wraps modulo DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
  - An entry pushed into an empty FIFO pops at the earliest on the following edge.
  - When full, in_ready=0, so no push occurs, even when a pop happens that cycle.
- FSM states: IDLE, SKEW, SETTLE.
  - IDLE, on pop: b<=head.b, a_pend<=head.a, cnt<=LATE_DLY-1, go to SKEW. a_late keeps its previous value.
  - SKEW: if cnt==0, a_late<=a_pend, cnt<=SETTLE-1, go to SETTLE; else cnt<=cnt-1.
  - SETTLE: if cnt==0, res_data<=out_fb, res_valid<=1, go to IDLE; else cnt<=cnt-1.
- Timing for a pop at edge T:
  - b changes at T.
  - a_late changes at T+LATE_DLY.
  - out_fb is sampled at edge T+LATE_DLY+SETTLE.
  - With default parameters: b at edge 1, a_late at edge 2, capture at edge 3 relative to push at edge 0.
- Throughput: one op per LATE_DLY+SETTLE+1 cycles when the result is consumed immediately.
- Result handshake:
  - res_valid && res_ready clears res_valid unless a new capture happens on the same edge; a new capture wins and sets res_valid=1.
  - res_data and res_valid stay stable while res_valid && !res_ready.
  - No pop occurs while a result is stalled.
- b and a_late hold their last values between ops; they never return to 0 except on reset.
- Width: all data is WIDTH bits and passes through unmodified; no arithmetic is performed on the data.
- in_a and in_b are don't-care when in_valid=0.

Test Plan:
- Bench model for all scenarios: out_fb = a_late ^ b.
- Reset: assert rst_n=0 mid-SKEW with 3 entries queued -> b, a_late, res_valid and res_data are 0 immediately (no clock edge needed); in_ready=1, busy=0; after release no result appears.
- Single op, defaults, res_ready=1: push a=2, b=3 at edge 0 ->
  - b=3, a_late=0 after edge 1 (out_fb=3 transiently);
  - a_late=2 after edge 2;
  - res_valid=1, res_data=1 after edge 3; res_valid=0 after edge 4.
- Fill and backpressure: res_ready=0, push 6 pairs back to back ->
  - exactly 5 pairs accepted (1 in flight + 4 queued);
  - in_ready=0 from then on;
  - res_data holds the first result.
  - Raising res_ready drains 6 results in push order.
- Wrap-around: with DEPTH=4, push and drain 10 ops -> results match the a^b order; pointers wrap with no loss or duplication.
- Parameters LATE_DLY=3, SETTLE=2: push a=7, b=5 ->
  - a_late updates 3 edges after b;
  - capture 2 edges after that, res_data=2;
  - back-to-back ops spaced 6 cycles.
- Same-edge events:
  - res_ready=1 on the edge where a new capture occurs -> res_valid stays 1 with the new data.
  - Push at full while a pop occurs -> push not taken (in_ready was 0).
